// File: rtl/sw_capture.sv
// Switch capture: two-flop synchroniser, whole-vector debounce FSM and a
// valid/ack event handshake so the consumer only loads settled, changed values.
module sw_capture #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_changed,
    output logic             sw_valid,
    input  logic             sw_ack,
    output logic             overrun,
    output logic             settling
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        SETTLING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] sync1_r, sync2_r;
    logic [WIDTH-1:0] candidate_r, candidate_nxt_s;
    logic [WIDTH-1:0] sw_out_r, sw_out_nxt_s;
    logic [WIDTH-1:0] last_acked_r, last_acked_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             sw_valid_r, sw_valid_nxt_s;
    logic             overrun_r, overrun_nxt_s;
    logic             commit_s;
    logic             ack_s;

    // State register, synchroniser and handshake registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            sync1_r      <= '0;
            sync2_r      <= '0;
            candidate_r  <= '0;
            sw_out_r     <= '0;
            last_acked_r <= '0;
            cnt_r        <= '0;
            sw_valid_r   <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            sync1_r      <= sw_raw;
            sync2_r      <= sync1_r;
            candidate_r  <= candidate_nxt_s;
            sw_out_r     <= sw_out_nxt_s;
            last_acked_r <= last_acked_nxt_s;
            cnt_r        <= cnt_nxt_s;
            sw_valid_r   <= sw_valid_nxt_s;
            overrun_r    <= overrun_nxt_s;
        end
    end

    // Debounce next-state logic; a commit happens only after CNT_MAX+1 matching cycles
    always_comb begin
        state_nxt_s     = state_r;
        candidate_nxt_s = candidate_r;
        cnt_nxt_s       = cnt_r;
        commit_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync2_r != sw_out_r) begin
                    candidate_nxt_s = sync2_r;
                    cnt_nxt_s       = '0;
                    state_nxt_s     = SETTLING;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETTLING: begin
                if ((sync2_r != candidate_r) && (sync2_r == sw_out_r)) begin
                    candidate_nxt_s = sw_out_r;
                    cnt_nxt_s       = '0;
                    state_nxt_s     = IDLE;
                end else if (sync2_r != candidate_r) begin
                    candidate_nxt_s = sync2_r;
                    cnt_nxt_s       = '0;
                end else if (cnt_r == CNT_MAX) begin
                    commit_s    = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                candidate_nxt_s = sw_out_r;
                cnt_nxt_s       = '0;
            end
        endcase
    end

    // Handshake: an ack captures the pre-commit word, so a same-edge commit stays pending
    always_comb begin
        ack_s            = sw_ack && sw_valid_r;
        last_acked_nxt_s = ack_s ? sw_out_r : last_acked_r;
        sw_out_nxt_s     = commit_s ? candidate_r : sw_out_r;
        if (commit_s) begin
            sw_valid_nxt_s = (candidate_r != last_acked_nxt_s);
        end else if (ack_s) begin
            sw_valid_nxt_s = 1'b0;
        end else begin
            sw_valid_nxt_s = sw_valid_r;
        end
        if (ack_s) begin
            overrun_nxt_s = 1'b0;
        end else if (commit_s && sw_valid_r) begin
            overrun_nxt_s = 1'b1;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    assign sw_out     = sw_out_r;
    assign sw_valid   = sw_valid_r;
    assign overrun    = overrun_r;
    assign settling   = (state_r == SETTLING);
    assign sw_changed = sw_out_r ^ last_acked_r;

endmodule

// File: tb/tb_sw_capture.sv
// Directed self-checking bench for sw_capture with DEBOUNCE_CYCLES=4, WIDTH=8.
module tb_sw_capture;

    logic       clk;
    logic       reset;
    logic [7:0] sw_raw;
    logic [7:0] sw_out;
    logic [7:0] sw_changed;
    logic       sw_valid;
    logic       sw_ack;
    logic       overrun;
    logic       settling;

    int n_asserts = 0;
    int n_fail    = 0;

    sw_capture #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_raw(sw_raw),
        .sw_out(sw_out),
        .sw_changed(sw_changed),
        .sw_valid(sw_valid),
        .sw_ack(sw_ack),
        .overrun(overrun),
        .settling(settling)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Commit a new value from a quiet, acked state and acknowledge it.
    task automatic settle_ack(input logic [7:0] v);
        sw_raw = v;
        tick(7);
        chk("settle_out", sw_out, v);
        chk("settle_valid", {7'd0, sw_valid}, 8'd1);
        sw_ack = 1'b1;
        tick(1);
        sw_ack = 1'b0;
        chk("settle_ack_valid", {7'd0, sw_valid}, 8'd0);
        chk("settle_ack_changed", sw_changed, 8'h00);
    endtask

    initial begin
        reset  = 1'b1;
        sw_raw = 8'hFF;
        sw_ack = 1'b0;
        tick(3);
        chk("rst_out", sw_out, 8'h00);
        chk("rst_valid", {7'd0, sw_valid}, 8'd0);
        chk("rst_overrun", {7'd0, overrun}, 8'd0);
        chk("rst_settling", {7'd0, settling}, 8'd0);
        chk("rst_changed", sw_changed, 8'h00);

        // Edge 0 is the last edge with reset asserted.
        reset = 1'b0;
        tick(2);
        chk("rel_settling_e2", {7'd0, settling}, 8'd0);
        tick(1);
        chk("rel_settling_e3", {7'd0, settling}, 8'd1);
        tick(3);
        chk("rel_settling_e6", {7'd0, settling}, 8'd1);
        chk("rel_out_e6", sw_out, 8'h00);
        chk("rel_valid_e6", {7'd0, sw_valid}, 8'd0);
        tick(1);
        chk("rel_out_e7", sw_out, 8'hFF);
        chk("rel_valid_e7", {7'd0, sw_valid}, 8'd1);
        chk("rel_changed_e7", sw_changed, 8'hFF);
        chk("rel_settling_e7", {7'd0, settling}, 8'd0);
        sw_ack = 1'b1;
        tick(1);
        sw_ack = 1'b0;
        chk("rel_ack_valid", {7'd0, sw_valid}, 8'd0);
        chk("rel_ack_changed", sw_changed, 8'h00);

        settle_ack(8'h00);

        // Clean step with ack one cycle after sw_valid rises.
        sw_raw = 8'h5A;
        tick(6);
        chk("step_out_e6", sw_out, 8'h00);
        tick(1);
        chk("step_out_e7", sw_out, 8'h5A);
        chk("step_valid_e7", {7'd0, sw_valid}, 8'd1);
        chk("step_changed_e7", sw_changed, 8'h5A);
        tick(1);
        chk("step_valid_hold", {7'd0, sw_valid}, 8'd1);
        sw_ack = 1'b1;
        tick(1);
        sw_ack = 1'b0;
        chk("step_ack_valid", {7'd0, sw_valid}, 8'd0);
        chk("step_ack_changed", sw_changed, 8'h00);
        settle_ack(8'h00);

        // Bounce: 01 for two samples, 00 for one, then 01 steady.
        sw_raw = 8'h01;
        for (int i = 1; i <= 15; i++) begin
            tick(1);
            if (i == 2) sw_raw = 8'h00;
            if (i == 3) sw_raw = 8'h01;
            chk("bounce_out", sw_out, (i >= 10) ? 8'h01 : 8'h00);
            chk("bounce_valid", {7'd0, sw_valid}, (i >= 10) ? 8'd1 : 8'd0);
            chk("bounce_settling", {7'd0, settling},
                ((i >= 3 && i <= 4) || (i >= 6 && i <= 9)) ? 8'd1 : 8'd0);
        end
        sw_ack = 1'b1;
        tick(1);
        sw_ack = 1'b0;
        chk("bounce_ack_valid", {7'd0, sw_valid}, 8'd0);
        settle_ack(8'h00);

        // Bounce back to the current value: no commit.
        sw_raw = 8'h10;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (i == 2) sw_raw = 8'h00;
            chk("bback_out", sw_out, 8'h00);
            chk("bback_valid", {7'd0, sw_valid}, 8'd0);
            chk("bback_settling", {7'd0, settling}, (i == 3 || i == 4) ? 8'd1 : 8'd0);
        end

        // Overrun: two commits without an ack.
        sw_raw = 8'h03;
        tick(7);
        chk("ovr_out1", sw_out, 8'h03);
        chk("ovr_flag1", {7'd0, overrun}, 8'd0);
        sw_raw = 8'h07;
        tick(7);
        chk("ovr_out2", sw_out, 8'h07);
        chk("ovr_flag2", {7'd0, overrun}, 8'd1);
        chk("ovr_changed", sw_changed, 8'h07);
        chk("ovr_valid", {7'd0, sw_valid}, 8'd1);
        sw_ack = 1'b1;
        tick(1);
        sw_ack = 1'b0;
        chk("ovr_ack_valid", {7'd0, sw_valid}, 8'd0);
        chk("ovr_ack_flag", {7'd0, overrun}, 8'd0);
        chk("ovr_ack_changed", sw_changed, 8'h00);

        // Ack on the same edge as a new commit.
        settle_ack(8'h00);
        sw_raw = 8'h03;
        tick(7);
        chk("sim_pend", sw_out, 8'h03);
        sw_raw = 8'h0F;
        tick(6);
        sw_ack = 1'b1;
        tick(1);
        sw_ack = 1'b0;
        chk("sim_out", sw_out, 8'h0F);
        chk("sim_valid", {7'd0, sw_valid}, 8'd1);
        chk("sim_overrun", {7'd0, overrun}, 8'd0);
        chk("sim_changed", sw_changed, 8'h0C);
        sw_ack = 1'b1;
        tick(1);
        sw_ack = 1'b0;
        chk("sim_ack2_valid", {7'd0, sw_valid}, 8'd0);

        // Switches return to the acked value before ack: commit clears sw_valid.
        settle_ack(8'h00);
        sw_raw = 8'h03;
        tick(7);
        chk("ret_valid1", {7'd0, sw_valid}, 8'd1);
        chk("ret_changed1", sw_changed, 8'h03);
        sw_raw = 8'h00;
        tick(7);
        chk("ret_out", sw_out, 8'h00);
        chk("ret_valid2", {7'd0, sw_valid}, 8'd0);
        chk("ret_changed2", sw_changed, 8'h00);
        chk("ret_overrun", {7'd0, overrun}, 8'd1);

        // Reset in the middle of a settle aborts it.
        sw_raw = 8'h55;
        tick(4);
        chk("mid_settling", {7'd0, settling}, 8'd1);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_out", sw_out, 8'h00);
        chk("mid_rst_settling", {7'd0, settling}, 8'd0);
        chk("mid_rst_overrun", {7'd0, overrun}, 8'd0);
        chk("mid_rst_valid", {7'd0, sw_valid}, 8'd0);
        sw_raw = 8'h00;
        tick(1);
        reset = 1'b0;
        tick(10);
        chk("post_rst_out", sw_out, 8'h00);
        chk("post_rst_valid", {7'd0, sw_valid}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
